// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 16x-oversampling UART transmitter. It sends 8 data bits LSB first, with
// optional even or odd parity and 1 or 2 stop bits. A small FIFO decouples
// the bus-side writer from the serial line. The baud_div, parity and stop2
// encoding matches the companion receiver, so one register set drives both.
//
// Optional feature (macro UART_TX_BREAK_EN):
//   When defined, the break_i input is added. Asserting break_i while idle
//   holds the line low. An in-progress frame finishes first. After break_i
//   is released, the line is held high for at least one full bit period
//   before the next frame may start.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   data_i     byte to transmit
//   valid_i    push request; accepted when valid_i && ready_o at clk edge
//   ready_o    FIFO not full
//   baud_div   tick divider; tick period = baud_div+1 clocks
//   parity     0=None, 1=Even, 2=Odd, 3=None
//   stop2      0=1 stop bit, 1=2 stop bits
//   break_i    line break request (only with UART_TX_BREAK_EN)
//   tx_o       serial line, idle high (registered)
//   busy_o     frame in progress or FIFO non-empty (registered)
//   done_o     one-clock pulse at the end of each frame's last stop bit
//   fifo_level current FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter logic [7:0] OVERSAMPLE = 8'd16,
    parameter int          FIFO_DEPTH = 4,
    parameter int          LVL_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [15:0]      baud_div,
    input  logic [1:0]       parity,
    input  logic             stop2,
`ifdef UART_TX_BREAK_EN
    input  logic             break_i,
`endif
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_ZERO  = LVL_W'(0);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [7:0]       OS_MAX    = OVERSAMPLE - 8'd1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PAR     = 3'd3,
        ST_STOP1   = 3'd4,
        ST_STOP2   = 3'd5,
        ST_BRK     = 3'd6,
        ST_POSTBRK = 3'd7
    } state_t;

    // Parity bit for a frame: even = XOR of data, odd = its complement.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
        logic p;
        case (mode)
            2'd1:    p = ^data;
            2'd2:    p = ~(^data);
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    // Mode 3 is treated like "no parity".
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == 2'd1) || (mode == 2'd2);
    endfunction

    // ------------------------------------------------------------------ signals
    logic             break_s;
    logic [15:0]      div_r;
    logic             tick_s;
    logic             bit_end_s;

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_nxt_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_ne_s;
    logic [7:0]       head_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             frame_load_s;
    logic             start_ok_s;

    logic [7:0]       os_r;
    logic [7:0]       os_nxt_s;
    logic [2:0]       bit_r;
    logic [2:0]       bit_nxt_s;
    logic [7:0]       shift_r;
    logic             par_en_r;
    logic             par_bit_r;
    logic             stop2_r;
    logic             tx_r;
    logic             tx_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             ready_r;

`ifdef UART_TX_BREAK_EN
    assign break_s = break_i;
`else
    assign break_s = 1'b0;
`endif

    // ------------------------------------------------------------ tick divider
    assign tick_s    = (div_r == 16'd0);
    assign bit_end_s = tick_s && (os_r == 8'd0);

    // Free-running divider; a new baud_div is only picked up on reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= 16'd0;
        end else if (tick_s) begin
            div_r <= baud_div;
        end else begin
            div_r <= div_r - 16'd1;
        end
    end

    // -------------------------------------------------------------------- FIFO
    assign push_s    = valid_i && (level_r != LVL_FULL);
    assign pop_s     = frame_load_s;
    assign fifo_ne_s = (level_r != LVL_ZERO);
    assign head_s    = mem_r[rd_ptr_r];

    // Occupancy update; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // FIFO storage and pointers. Storage is not reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= LVL_ZERO;
            ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= data_i;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            level_r <= level_nxt_s;
            ready_r <= (level_nxt_s != LVL_FULL);
        end
    end

    // --------------------------------------------------------------------- FSM
    // A queued byte may start unless a break request is pending.
    assign start_ok_s = fifo_ne_s && !break_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. The last stop bit chains straight into the next start bit.
    always_comb begin
        state_nxt_s  = state_r;
        frame_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (break_s) begin
                    state_nxt_s = ST_BRK;
                end else if (tick_s && fifo_ne_s) begin
                    state_nxt_s  = ST_START;
                    frame_load_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (bit_r == 3'd7)) begin
                    state_nxt_s = par_en_r ? ST_PAR : ST_STOP1;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PAR: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_STOP1;
                end else begin
                    state_nxt_s = ST_PAR;
                end
            end
            ST_STOP1: begin
                if (bit_end_s && stop2_r) begin
                    state_nxt_s = ST_STOP2;
                end else if (bit_end_s && start_ok_s) begin
                    state_nxt_s  = ST_START;
                    frame_load_s = 1'b1;
                end else if (bit_end_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP1;
                end
            end
            ST_STOP2: begin
                if (bit_end_s && start_ok_s) begin
                    state_nxt_s  = ST_START;
                    frame_load_s = 1'b1;
                end else if (bit_end_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP2;
                end
            end
            ST_BRK: begin
                if (!break_s) begin
                    state_nxt_s = ST_POSTBRK;
                end else begin
                    state_nxt_s = ST_BRK;
                end
            end
            ST_POSTBRK: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_POSTBRK;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values: bit timing, line level, done and busy.
    always_comb begin
        os_nxt_s   = os_r;
        bit_nxt_s  = bit_r;
        done_nxt_s = 1'b0;
        tx_nxt_s   = 1'b1;

        if (frame_load_s) begin
            os_nxt_s  = OS_MAX;
            bit_nxt_s = 3'd0;
        end else if (state_r == ST_BRK) begin
            // Prime the post-break idle so it lasts a full bit period.
            os_nxt_s  = OS_MAX;
        end else if ((state_r != ST_IDLE) && tick_s) begin
            if (os_r != 8'd0) begin
                os_nxt_s = os_r - 8'd1;
            end else begin
                os_nxt_s = OS_MAX;
                if (state_r == ST_DATA) begin
                    bit_nxt_s = bit_r + 3'd1;
                end else begin
                    bit_nxt_s = bit_r;
                end
            end
        end else begin
            os_nxt_s = os_r;
        end

        if (bit_end_s && (((state_r == ST_STOP1) && !stop2_r) || (state_r == ST_STOP2))) begin
            done_nxt_s = 1'b1;
        end else begin
            done_nxt_s = 1'b0;
        end

        case (state_nxt_s)
            ST_START: tx_nxt_s = 1'b0;
            ST_DATA:  tx_nxt_s = shift_r[bit_nxt_s];
            ST_PAR:   tx_nxt_s = par_bit_r;
            ST_BRK:   tx_nxt_s = 1'b0;
            default:  tx_nxt_s = 1'b1;
        endcase

        busy_nxt_s = (state_nxt_s != ST_IDLE) || (level_nxt_s != LVL_ZERO);
    end

    // Frame datapath and registered outputs; parity and stop2 are frozen per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            os_r      <= 8'd0;
            bit_r     <= 3'd0;
            shift_r   <= 8'd0;
            par_en_r  <= 1'b0;
            par_bit_r <= 1'b0;
            stop2_r   <= 1'b0;
            tx_r      <= 1'b1;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            os_r   <= os_nxt_s;
            bit_r  <= bit_nxt_s;
            tx_r   <= tx_nxt_s;
            done_r <= done_nxt_s;
            busy_r <= busy_nxt_s;
            if (frame_load_s) begin
                shift_r   <= head_s;
                par_en_r  <= parity_enabled(parity);
                par_bit_r <= parity_bit(head_s, parity);
                stop2_r   <= stop2;
            end else begin
                shift_r   <= shift_r;
                par_en_r  <= par_en_r;
                par_bit_r <= par_bit_r;
                stop2_r   <= stop2_r;
            end
        end
    end

    assign tx_o       = tx_r;
    assign done_o     = done_r;
    assign busy_o     = busy_r;
    assign ready_o    = ready_r;
    assign fifo_level = level_r;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Directed self-checking bench for uart_tx with OVERSAMPLE=16 and
// FIFO_DEPTH=4. Each frame is captured from its start bit. The bench then
// reads the middle sample of every bit, checks that each bit period is stable,
// and checks the done_o/busy_o timing against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx;

    logic        clk;
    logic        rst;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] baud_div;
    logic [1:0]  parity;
    logic        stop2;
`ifdef UART_TX_BREAK_EN
    logic        break_i;
`endif
    logic        tx_o;
    logic        busy_o;
    logic        done_o;
    logic [2:0]  fifo_level;

    int n_cmp = 0;
    int n_bad = 0;

    logic tx_q   [0:32999];
    logic done_q [0:32999];
    logic busy_q [0:32999];

    uart_tx #(
        .OVERSAMPLE (8'd16),
        .FIFO_DEPTH (4),
        .LVL_W      (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .baud_div   (baud_div),
        .parity     (parity),
        .stop2      (stop2),
`ifdef UART_TX_BREAK_EN
        .break_i    (break_i),
`endif
        .tx_o       (tx_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        data_i  = b;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
    endtask

    // Wait (bounded) for a start bit, then record n samples from it.
    // At sample index flip_at, stop2 and parity are changed mid-frame.
    task automatic capture(input int n, input int flip_at);
        logic found;
        found = 1'b0;
        for (int w = 0; w < 20000 && !found; w++) begin
            step();
            if (tx_o === 1'b0) found = 1'b1;
        end
        check("start_seen", found, 1'b1);
        if (found) begin
            tx_q[0] = tx_o; done_q[0] = done_o; busy_q[0] = busy_o;
            for (int i = 1; i < n; i++) begin
                if (i == flip_at) begin
                    stop2  = ~stop2;
                    parity = 2'd1;
                end
                step();
                tx_q[i] = tx_o; done_q[i] = done_o; busy_q[i] = busy_o;
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                tx_q[i] = 1'b1; done_q[i] = 1'b0; busy_q[i] = 1'b0;
            end
        end
    endtask

    // nbits is the total bit count across nframes back-to-back frames.
    task automatic check_frame(input string tag, input logic [63:0] exp, input int nbits,
                               input int bclk, input int nframes);
        logic [63:0] got;
        int gl, dcnt, dlast, total;
        got = 64'd0; gl = 0; dcnt = 0; dlast = -1;
        total = nbits * bclk;
        for (int k = 0; k < nbits; k++) got[k] = tx_q[k*bclk + bclk/2];
        for (int i = 0; i < total; i++)
            if (tx_q[i] !== tx_q[(i/bclk)*bclk + bclk/2]) gl++;
        for (int i = 0; i < total + 3; i++)
            if (done_q[i] === 1'b1) begin dcnt++; dlast = i; end
        check({tag, "/bits"},       got, exp);
        check({tag, "/glitches"},   gl, 0);
        check({tag, "/done_count"}, dcnt, nframes);
        check({tag, "/done_at"},    dlast, total);
        check({tag, "/busy_end"},   busy_q[total-1], 1'b1);
        check({tag, "/busy_after"}, busy_q[total], 1'b0);
    endtask

    task automatic idle_watch(input string tag, input int n);
        int lows, dones;
        lows = 0; dones = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (tx_o !== 1'b1) lows++;
            if (done_o !== 1'b0) dones++;
        end
        check({tag, "/tx_low"}, lows, 0);
        check({tag, "/done"},   dones, 0);
    endtask

    initial begin
        rst = 1'b1; data_i = 8'd0; valid_i = 1'b0; baud_div = 16'd0;
        parity = 2'd0; stop2 = 1'b0;
`ifdef UART_TX_BREAK_EN
        break_i = 1'b0;
`endif
        repeat (3) step();
        check("rst/tx",    tx_o, 1'b1);
        check("rst/busy",  busy_o, 1'b0);
        check("rst/done",  done_o, 1'b0);
        check("rst/level", fifo_level, 3'd0);
        check("rst/ready", ready_o, 1'b1);
        rst = 1'b0;

        // 0x55, no parity, one stop bit: 160 clocks.
        push(8'h55);
        capture(163, -1);
        check_frame("p0_55", {1'b1, 8'h55, 1'b0}, 10, 16, 1);

        // Even parity of 0x07 (three ones) -> 1; 176 clocks.
        parity = 2'd1;
        push(8'h07);
        capture(179, -1);
        check_frame("even_07", {1'b1, 1'b1, 8'h07, 1'b0}, 11, 16, 1);

        // Odd parity of 0x07 -> 0.
        parity = 2'd2;
        push(8'h07);
        capture(179, -1);
        check_frame("odd_07", {1'b1, 1'b0, 8'h07, 1'b0}, 11, 16, 1);

        // Mode 3 sends no parity bit.
        parity = 2'd3;
        push(8'h07);
        capture(163, -1);
        check_frame("p3_07", {1'b1, 8'h07, 1'b0}, 10, 16, 1);

        // Two stop bits at baud_div=1: 11 bits x 32 clocks = 352 clocks.
        // The config is changed mid-frame and must not affect this frame.
        parity = 2'd0; stop2 = 1'b1; baud_div = 16'd1;
        push(8'hA3);
        capture(355, 100);
        check_frame("stop2_A3", {2'b11, 8'hA3, 1'b0}, 11, 32, 1);

        // Reset during data bit 3 of 0x35 (bit 3 = 0), with 0xC3 still queued.
        parity = 2'd0; stop2 = 1'b0; baud_div = 16'd0;
        push(8'h35);
        push(8'hC3);
        capture(1, -1);
        repeat (68) step();
        check("mid/tx_bit3", tx_o, 1'b0);
        check("mid/level",   fifo_level, 3'd1);
        rst = 1'b1;
        step();
        check("abort/tx",    tx_o, 1'b1);
        check("abort/level", fifo_level, 3'd0);
        check("abort/done",  done_o, 1'b0);
        check("abort/busy",  busy_o, 1'b0);
        check("abort/ready", ready_o, 1'b1);
        rst = 1'b0;
        idle_watch("post_rst", 300);
        push(8'h96);
        capture(163, -1);
        check_frame("after_rst_96", {1'b1, 8'h96, 1'b0}, 10, 16, 1);

        // FIFO fill at baud_div=50: the first tick follows reset release, the next is 51 clocks later.
        rst = 1'b1; baud_div = 16'd50;
        repeat (3) step();
        rst = 1'b0; valid_i = 1'b1; data_i = 8'h11;
        step();
        check("fill1/level", fifo_level, 3'd1);
        check("fill1/ready", ready_o, 1'b1);
        data_i = 8'h12; step();
        check("fill2/level", fifo_level, 3'd2);
        data_i = 8'h13; step();
        check("fill3/level", fifo_level, 3'd3);
        data_i = 8'h14; step();
        check("fill4/level", fifo_level, 3'd4);
        check("fill4/ready", ready_o, 1'b0);
        data_i = 8'h15; step();
        check("fill5/level", fifo_level, 3'd4);
        check("fill5/ready", ready_o, 1'b0);
        valid_i = 1'b0;
        capture(32643, -1);
        check_frame("fifo_b2b", {1'b1, 8'h14, 1'b0, 1'b1, 8'h13, 1'b0,
                                 1'b1, 8'h12, 1'b0, 1'b1, 8'h11, 1'b0}, 40, 816, 4);
        idle_watch("fifo_drop", 2000);

`ifdef UART_TX_BREAK_EN
        begin
            int hi_cnt, brk_hi;
            logic seen;
            baud_div = 16'd0;
            break_i = 1'b1;
            step();
            check("brk/tx_low", tx_o, 1'b0);
            brk_hi = 0;
            for (int i = 0; i < 1000; i++) begin
                if (i == 10) begin data_i = 8'h5A; valid_i = 1'b1; end
                if (i == 11) valid_i = 1'b0;
                step();
                if (tx_o !== 1'b0) brk_hi++;
            end
            check("brk/held", brk_hi, 0);
            check("brk/busy", busy_o, 1'b1);
            break_i = 1'b0;
            hi_cnt = 0; seen = 1'b0;
            for (int w = 0; w < 500 && !seen; w++) begin
                step();
                if (tx_o === 1'b0) seen = 1'b1;
                else hi_cnt++;
            end
            check("brk/start_after", seen, 1'b1);
            check("brk/idle_ge_bit", (hi_cnt >= 16), 1'b1);
            repeat (200) step();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
16x-oversampling UART transmitter: 8 data bits LSB-first, optional even/odd parity, 1 or 2 stop bits. It is the transmit-side peer of the block's UART receiver and uses the same baud_div, parity and stop2 configuration encoding, so one register set drives both directions. A small input FIFO decouples the bus-side writer from the serial line. The block sits between the peripheral register interface and the tx pin.

Parameters:
OVERSAMPLE, 8'd16, ticks per bit period (must be >= 1)
FIFO_DEPTH, 4, transmit FIFO entries (power of 2, >= 2)
LVL_W, 3, width of fifo_level (must hold 0..FIFO_DEPTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
data_i  in  8  byte to transmit
valid_i  in  1  push request; byte accepted when valid_i && ready_o at clk edge
ready_o  out  1  FIFO not full
baud_div  in  16  tick divider; tick period = baud_div+1 clocks
parity  in  2  0=None, 1=Even, 2=Odd, 3=treated as None
stop2  in  1  0=1 stop bit, 1=2 stop bits
tx_o  out  1  serial line, idle high
busy_o  out  1  frame in progress or FIFO non-empty
done_o  out  1  one-clk pulse at end of each frame's last stop bit
fifo_level  out  LVL_W  current FIFO occupancy

Behaviour:
- Reset values: tx_o=1, busy_o=0, done_o=0, fifo_level=0, ready_o=1; FIFO emptied, FSM in IDLE, divider=0.
- Tick divider: free-running. If div==0, reload baud_div and pulse tick for one clock; otherwise decrement. Tick fires on the first clock after reset release.
- Bit timing: each bit (start, data, parity, stop) is held for exactly OVERSAMPLE ticks, i.e. OVERSAMPLE*(baud_div+1) clocks. tx_o is registered.
- FSM states: IDLE, START, DATA, PAR, STOP1, STOP2. All transitions occur only on a tick.
- IDLE: tx_o=1. On a tick with the FIFO non-empty:
  - pop the head into the shift register;
  - latch parity and stop2 for the whole frame, so mid-frame config changes have no effect;
  - compute the parity bit: Even = XOR of data, Odd = ~XOR of data;
  - drive tx_o=0, set os=OVERSAMPLE-1, go to START.
- In every non-IDLE state on a tick: if os!=0, decrement os. If os==0, reload os=OVERSAMPLE-1, drive the next bit and advance state.
- State sequence: START -> DATA (bits 0..7, LSB first, bit counter 0..7) -> PAR if latched parity is 1 or 2, otherwise STOP1 -> STOP2 if latched stop2, otherwise IDLE.
- STOP1 and STOP2 drive tx_o=1.
- On leaving the final stop state: done_o=1 for one clock. The next frame may start on the very next tick, giving back-to-back frames with no extra idle.
- FIFO: circular buffer with wrapping read/write pointers.
  - ready_o = (fifo_level != FIFO_DEPTH).
  - A push when full is ignored and the data is dropped.
  - Simultaneous push and pop: level unchanged, both pointers advance.
  - A push into an empty FIFO is visible to IDLE from the next clock.
- busy_o = (state != IDLE) || (fifo_level != 0), registered.
- baud_div change: takes effect at the next divider reload. The current count is not disturbed.
- Reset mid-frame: tx_o=1 on the next clock, frame aborted, FIFO contents discarded, no done_o pulse.

Optional Feature:
UART_TX_BREAK_EN:
- Defined: adds input port break_i (1 bit). When break_i=1 and the FSM is in IDLE, tx_o is driven 0 on the next clock and no frame starts. An in-progress frame completes first, then the break begins. On break_i deassert, tx_o=1 and a mandatory idle of one full bit period (OVERSAMPLE ticks) is held before any frame starts. busy_o=1 while break or post-break idle is active.
- Undefined: break_i port absent; tx_o idles high whenever no frame is active.

Test Plan:
- OVERSAMPLE=16, baud_div=0, parity=0, stop2=0, push 0x55 -> tx_o sequence 0,1,0,1,0,1,0,1,0,1, each 16 clks; frame=160 clks; done_o pulses once; busy_o falls afterwards.
- parity=1, push 0x07 -> parity bit 1, frame 176 clks (baud_div=0). parity=2, push 0x07 -> parity bit 0. parity=3 -> no parity bit.
- stop2=1, parity=0, baud_div=1 -> frame 11 bit periods = 352 clks, stop high for 64 clks. Changing stop2 mid-frame does not alter the frame.
- baud_div=50, push 0x11..0x15 back-to-back with valid_i held -> ready_o drops when fifo_level=4; rejected bytes absent from the line; accepted bytes appear in order, back-to-back with no inter-frame gap.
- Assert rst during DATA bit 3 -> tx_o=1 next clk, fifo_level=0, no done_o; a new push after reset transmits a correct frame.
- UART_TX_BREAK_EN: break_i=1 for 1000 clks while idle -> tx_o=0 throughout. After release, tx_o=1 for >= one bit period before a queued byte's start bit.
